// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: holds one multi-lane bundle, resolves the oldest flushing lane,
// drives GPR writes and flush/CSR info. Optional perf counters under WB_PERF_CNT_EN.
module wb_commit_stage #(
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ws_stall,
  output logic                  ws_allowin,
  input  logic                  ms_to_ws_valid,
  input  logic [LANES-1:0]      ms_lane_valid,
  input  logic [LANES*32-1:0]   ms_pc,
  input  logic [LANES-1:0]      ms_gr_we,
  input  logic [LANES*5-1:0]    ms_dest,
  input  logic [LANES*32-1:0]   ms_result,
  input  logic [LANES-1:0]      ms_excp,
  input  logic [LANES*6-1:0]    ms_ecode,
  input  logic [LANES*32-1:0]   ms_badv,
  input  logic [LANES-1:0]      ms_badv_vld,
  input  logic [LANES-1:0]      ms_ertn,
  input  logic [LANES-1:0]      ms_refetch,
  input  logic [LANES-1:0]      ms_br_inst,
  input  logic [LANES-1:0]      ms_br_mispred,
  output logic [LANES-1:0]      rf_we,
  output logic [LANES*5-1:0]    rf_waddr,
  output logic [LANES*32-1:0]   rf_wdata,
  output logic                  excp_flush,
  output logic                  ertn_flush,
  output logic                  refetch_flush,
  output logic [31:0]           csr_era,
  output logic [5:0]            csr_ecode,
  output logic                  va_error,
  output logic [31:0]           bad_va,
  output logic [LANES-1:0]      retire_mask,
  output logic [CNT_W-1:0]      perf_retired,
  output logic [CNT_W-1:0]      perf_br,
  output logic [CNT_W-1:0]      perf_mispred
);

  localparam int unsigned FW = $clog2(LANES + 1);

  logic                   ws_valid;
  logic [LANES-1:0]       ws_lane_valid, ws_gr_we, ws_excp, ws_badv_vld;
  logic [LANES-1:0]       ws_ertn, ws_refetch, ws_br_inst, ws_br_mispred;
  logic [LANES-1:0][31:0] ws_pc, ws_result, ws_badv;
  logic [LANES-1:0][4:0]  ws_dest;
  logic [LANES-1:0][5:0]  ws_ecode;

  logic                   active;
  logic                   flush_any;
  logic                   capture;
  logic                   has_flush;
  logic [FW-1:0]          flush_lane;
  logic [LANES-1:0]       commit, wr_cand, rf_we_c;
  logic [31:0]            f_pc, f_badv;
  logic [5:0]             f_ecode;
  logic                   f_excp, f_ertn, f_refetch, f_badv_vld;

  // reset forces the stage open so nothing stays held across it
  assign ws_allowin = reset || !ws_valid || !ws_stall;
  assign active     = ws_valid && !ws_stall && !reset;
  assign capture    = ms_to_ws_valid && ws_allowin && !flush_any;

  always_ff @(posedge clk) begin
    if (reset)          ws_valid <= 1'b0;
    else if (flush_any) ws_valid <= 1'b0;
    else if (ws_allowin) ws_valid <= ms_to_ws_valid;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      ws_lane_valid <= ms_lane_valid;
      ws_pc         <= ms_pc;
      ws_gr_we      <= ms_gr_we;
      ws_dest       <= ms_dest;
      ws_result     <= ms_result;
      ws_excp       <= ms_excp;
      ws_ecode      <= ms_ecode;
      ws_badv       <= ms_badv;
      ws_badv_vld   <= ms_badv_vld;
      ws_ertn       <= ms_ertn;
      ws_refetch    <= ms_refetch;
      ws_br_inst    <= ms_br_inst;
      ws_br_mispred <= ms_br_mispred;
    end
  end

  // oldest valid lane that redirects the front end; LANES when none
  always_comb begin
    has_flush  = 1'b0;
    flush_lane = FW'(LANES);
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!has_flush && ws_lane_valid[i] && (ws_excp[i] || ws_ertn[i] || ws_refetch[i])) begin
        has_flush  = 1'b1;
        flush_lane = FW'(i);
      end
    end
  end

  always_comb begin
    f_pc       = '0;
    f_badv     = '0;
    f_ecode    = '0;
    f_excp     = 1'b0;
    f_ertn     = 1'b0;
    f_refetch  = 1'b0;
    f_badv_vld = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (has_flush && flush_lane == FW'(i)) begin
        f_pc       = ws_pc[i];
        f_badv     = ws_badv[i];
        f_ecode    = ws_ecode[i];
        f_excp     = ws_excp[i];
        f_ertn     = ws_ertn[i];
        f_refetch  = ws_refetch[i];
        f_badv_vld = ws_badv_vld[i];
      end
    end
  end

  always_comb begin
    commit  = '0;
    wr_cand = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      commit[i]  = active && ws_lane_valid[i] &&
                   ((FW'(i) < flush_lane) || (FW'(i) == flush_lane && !ws_excp[i]));
      wr_cand[i] = commit[i] && ws_gr_we[i] && (ws_dest[i] != 5'd0);
    end
  end

  // a younger lane writing the same register makes the older write dead
  always_comb begin
    rf_we_c = wr_cand;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (wr_cand[j] && ws_dest[j] == ws_dest[i]) rf_we_c[i] = 1'b0;
      end
    end
  end

  assign excp_flush    = active && has_flush && f_excp;
  assign ertn_flush    = active && has_flush && f_ertn && !f_excp;
  assign refetch_flush = active && has_flush && f_refetch && !f_excp && !f_ertn;
  assign flush_any     = excp_flush || ertn_flush || refetch_flush;

  assign csr_era     = flush_any  ? f_pc    : '0;
  assign csr_ecode   = excp_flush ? f_ecode : '0;
  assign bad_va      = excp_flush ? f_badv  : '0;
  assign va_error    = excp_flush && f_badv_vld;

  assign rf_we       = rf_we_c;
  assign rf_waddr    = ws_dest;
  assign rf_wdata    = ws_result;
  assign retire_mask = commit;

`ifdef WB_PERF_CNT_EN
  logic [2:0]       n_ret, n_br, n_mis;
  logic [CNT_W-1:0] cnt_ret, cnt_br, cnt_mis;

  always_comb begin
    n_ret = '0;
    n_br  = '0;
    n_mis = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      n_ret = n_ret + {2'b00, commit[i]};
      n_br  = n_br  + {2'b00, commit[i] && ws_br_inst[i]};
      n_mis = n_mis + {2'b00, commit[i] && ws_br_mispred[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_ret <= '0;
      cnt_br  <= '0;
      cnt_mis <= '0;
    end else begin
      cnt_ret <= cnt_ret + CNT_W'(n_ret);
      cnt_br  <= cnt_br  + CNT_W'(n_br);
      cnt_mis <= cnt_mis + CNT_W'(n_mis);
    end
  end

  assign perf_retired = cnt_ret;
  assign perf_br      = cnt_br;
  assign perf_mispred = cnt_mis;
`else
  logic unused_br;
  assign unused_br    = ^{ws_br_inst, ws_br_mispred};
  assign perf_retired = '0;
  assign perf_br      = '0;
  assign perf_mispred = '0;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage (LANES=2, CNT_W=4): directed scenarios then random traffic,
// checked against a lane-list reference model.
module tb_wb_commit_stage;
  localparam int L  = 2;
  localparam int CW = 4;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic        excp;
    logic [5:0]  ecode;
    logic [31:0] badv;
    logic        bv;
    logic        ertn;
    logic        refetch;
    logic        br;
    logic        mis;
  } lane_t;

  logic            clk;
  logic            reset;
  logic            ws_stall;
  logic            ws_allowin;
  logic            ms_to_ws_valid;
  logic [L-1:0]    ms_lane_valid, ms_gr_we, ms_excp, ms_badv_vld, ms_ertn, ms_refetch;
  logic [L-1:0]    ms_br_inst, ms_br_mispred;
  logic [L*32-1:0] ms_pc, ms_result, ms_badv;
  logic [L*5-1:0]  ms_dest;
  logic [L*6-1:0]  ms_ecode;
  logic [L-1:0]    rf_we, retire_mask;
  logic [L*5-1:0]  rf_waddr;
  logic [L*32-1:0] rf_wdata;
  logic            excp_flush, ertn_flush, refetch_flush, va_error;
  logic [31:0]     csr_era, bad_va;
  logic [5:0]      csr_ecode;
  logic [CW-1:0]   perf_retired, perf_br, perf_mispred;

  wb_commit_stage #(.LANES(L), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ws_stall(ws_stall), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_lane_valid(ms_lane_valid), .ms_pc(ms_pc),
    .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result), .ms_excp(ms_excp),
    .ms_ecode(ms_ecode), .ms_badv(ms_badv), .ms_badv_vld(ms_badv_vld), .ms_ertn(ms_ertn),
    .ms_refetch(ms_refetch), .ms_br_inst(ms_br_inst), .ms_br_mispred(ms_br_mispred),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .excp_flush(excp_flush),
    .ertn_flush(ertn_flush), .refetch_flush(refetch_flush), .csr_era(csr_era),
    .csr_ecode(csr_ecode), .va_error(va_error), .bad_va(bad_va), .retire_mask(retire_mask),
    .perf_retired(perf_retired), .perf_br(perf_br), .perf_mispred(perf_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  lane_t in_l[L];
  lane_t m_l[L];
  logic  in_valid, in_stall, in_reset;
  bit    m_valid = 1'b0;
  int    m_ret = 0, m_br = 0, m_mis = 0;
  bit    exp_flush, exp_allow;
  bit [L-1:0] exp_com;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic lane_t mk(bit v, logic [31:0] pc, bit we, logic [4:0] d, logic [31:0] r);
    lane_t t;
    t.v = v; t.pc = pc; t.gr_we = we; t.dest = d; t.res = r;
    t.excp = 1'b0; t.ecode = '0; t.badv = '0; t.bv = 1'b0;
    t.ertn = 1'b0; t.refetch = 1'b0; t.br = 1'b0; t.mis = 1'b0;
    return t;
  endfunction

  function automatic lane_t rnd_lane();
    lane_t t;
    t.v = ($urandom_range(0, 3) != 0); t.pc = $urandom; t.gr_we = $urandom_range(0, 1);
    t.dest = 5'($urandom_range(0, 7)); t.res = $urandom;
    t.excp = ($urandom_range(0, 9) == 0); t.ecode = 6'($urandom); t.badv = $urandom;
    t.bv = $urandom_range(0, 1); t.ertn = ($urandom_range(0, 11) == 0);
    t.refetch = ($urandom_range(0, 9) == 0); t.br = ($urandom_range(0, 2) == 0);
    t.mis = ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  task automatic idle();
    in_valid = 1'b0;
    for (int i = 0; i < L; i++) in_l[i] = mk(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic apply_inputs();
    reset = in_reset; ws_stall = in_stall; ms_to_ws_valid = in_valid;
    for (int i = 0; i < L; i++) begin
      ms_lane_valid[i] = in_l[i].v;       ms_pc[i*32 +: 32]     = in_l[i].pc;
      ms_gr_we[i]      = in_l[i].gr_we;   ms_dest[i*5 +: 5]     = in_l[i].dest;
      ms_result[i*32 +: 32] = in_l[i].res; ms_excp[i]           = in_l[i].excp;
      ms_ecode[i*6 +: 6] = in_l[i].ecode; ms_badv[i*32 +: 32]   = in_l[i].badv;
      ms_badv_vld[i]   = in_l[i].bv;      ms_ertn[i]            = in_l[i].ertn;
      ms_refetch[i]    = in_l[i].refetch; ms_br_inst[i]         = in_l[i].br;
      ms_br_mispred[i] = in_l[i].mis;
    end
  endtask

  task automatic check_outputs();
    bit active, ef, erf, rff, vae;
    int f;
    bit [L-1:0] com, wr, we;
    logic [31:0] era, bva;
    logic [5:0] ec;
    int pr, pb, pm;
    active = m_valid && !in_stall && !in_reset;
    f = L;
    for (int i = 0; i < L; i++)
      if (f == L && m_l[i].v && (m_l[i].excp || m_l[i].ertn || m_l[i].refetch)) f = i;
    for (int i = 0; i < L; i++) begin
      com[i] = active && m_l[i].v && (i < f || (i == f && !m_l[i].excp));
      wr[i]  = com[i] && m_l[i].gr_we && (m_l[i].dest != 0);
    end
    we = wr;
    for (int i = 0; i < L; i++)
      for (int j = i + 1; j < L; j++)
        if (wr[j] && m_l[j].dest == m_l[i].dest) we[i] = 1'b0;
    ef = 0; erf = 0; rff = 0; vae = 0; era = '0; bva = '0; ec = '0;
    if (active && f < L) begin
      ef  = m_l[f].excp;
      erf = m_l[f].ertn && !ef;
      rff = m_l[f].refetch && !ef && !m_l[f].ertn;
      if (ef || erf || rff) era = m_l[f].pc;
      if (ef) begin ec = m_l[f].ecode; bva = m_l[f].badv; vae = m_l[f].bv; end
    end
    exp_allow = in_reset || !m_valid || !in_stall;
    exp_flush = ef || erf || rff;
    exp_com   = com;
`ifdef WB_PERF_CNT_EN
    pr = m_ret; pb = m_br; pm = m_mis;
`else
    pr = 0; pb = 0; pm = 0;
`endif
    check_eq("allowin", ws_allowin, exp_allow);
    check_eq("rf_we", rf_we, we);
    check_eq("retire_mask", retire_mask, com);
    check_eq("excp_flush", excp_flush, ef);
    check_eq("ertn_flush", ertn_flush, erf);
    check_eq("refetch_flush", refetch_flush, rff);
    check_eq("csr_era", csr_era, era);
    check_eq("csr_ecode", csr_ecode, ec);
    check_eq("bad_va", bad_va, bva);
    check_eq("va_error", va_error, vae);
    check_eq("perf_retired", perf_retired, pr);
    check_eq("perf_br", perf_br, pb);
    check_eq("perf_mispred", perf_mispred, pm);
    for (int i = 0; i < L; i++)
      if (we[i]) begin
        check_eq("rf_waddr", rf_waddr[i*5 +: 5], m_l[i].dest);
        check_eq("rf_wdata", rf_wdata[i*32 +: 32], m_l[i].res);
      end
  endtask

  task automatic update_model();
    int nr, nb, nm;
    nr = 0; nb = 0; nm = 0;
    for (int i = 0; i < L; i++)
      if (exp_com[i]) begin
        nr++;
        if (m_l[i].br) nb++;
        if (m_l[i].mis) nm++;
      end
    if (in_reset) begin
      m_valid = 0; m_ret = 0; m_br = 0; m_mis = 0;
    end else begin
      m_ret = (m_ret + nr) % (1 << CW);
      m_br  = (m_br + nb) % (1 << CW);
      m_mis = (m_mis + nm) % (1 << CW);
      if (exp_flush) m_valid = 0;
      else if (exp_allow) begin
        m_valid = in_valid;
        if (in_valid) m_l = in_l;
      end
    end
  endtask

  task automatic settle();
    apply_inputs(); #2; check_outputs();
  endtask

  task automatic advance();
    @(posedge clk); update_model(); #1;
  endtask

  task automatic step();
    settle(); advance();
  endtask

  task automatic offer2(logic [31:0] pc, logic [4:0] d0, logic [4:0] d1);
    in_valid = 1'b1;
    in_l[0] = mk(1'b1, pc, 1'b1, d0, pc ^ 32'h5a5a_0000);
    in_l[1] = mk(1'b1, pc + 4, 1'b1, d1, pc ^ 32'ha5a5_0000);
  endtask

  initial begin
    for (int i = 0; i < L; i++) m_l[i] = mk(1'b0, '0, 1'b0, '0, '0);
    in_reset = 1'b1; in_stall = 1'b0; idle();
    apply_inputs();
    @(posedge clk); #1;
    step();
    in_reset = 1'b0;

    // both lanes write distinct registers
    in_valid = 1'b1;
    in_l[0] = mk(1'b1, 32'h100, 1'b1, 5'd3, 32'haaaa);
    in_l[1] = mk(1'b1, 32'h104, 1'b1, 5'd4, 32'hbbbb);
    step();
    idle(); settle();
    check_eq("r22_rf_we", rf_we, 2'b11);
    check_eq("r22_retire", retire_mask, 2'b11);
    advance();
    settle();
`ifdef WB_PERF_CNT_EN
    check_eq("r22_perf", perf_retired, 2);
`else
    check_eq("r22_perf", perf_retired, 0);
`endif
    advance();

    // exception on lane 0 kills lane 1; bundle offered during flush is dropped
    in_valid = 1'b1;
    in_l[0] = mk(1'b1, 32'h200, 1'b1, 5'd5, 32'h1);
    in_l[0].excp = 1'b1; in_l[0].ecode = 6'h09; in_l[0].badv = 32'h1003; in_l[0].bv = 1'b1;
    in_l[1] = mk(1'b1, 32'h204, 1'b1, 5'd6, 32'h2);
    step();
    offer2(32'h800, 5'd8, 5'd9);
    settle();
    check_eq("r23_excp", excp_flush, 1);
    check_eq("r23_era", csr_era, 32'h200);
    check_eq("r23_badva", bad_va, 32'h1003);
    check_eq("r23_ecode", csr_ecode, 6'h09);
    check_eq("r23_rf_we", rf_we, 2'b00);
    advance();
    idle(); settle();
    check_eq("r23_dropped", retire_mask, 2'b00);
    advance();

    // refetch on the younger lane still commits both
    offer2(32'h300, 5'd10, 5'd11);
    in_l[1].refetch = 1'b1;
    step();
    idle(); settle();
    check_eq("r24_rf_we", rf_we, 2'b11);
    check_eq("r24_refetch", refetch_flush, 1);
    check_eq("r24_era", csr_era, 32'h304);
    advance();

    // same destination in both lanes
    offer2(32'h400, 5'd7, 5'd7);
    step();
    idle(); settle();
    check_eq("r25_rf_we", rf_we, 2'b10);
    check_eq("r25_wdata1", rf_wdata[63:32], 32'h400 ^ 32'ha5a5_0000);
    advance();

    // three-cycle stall with a held bundle
    offer2(32'h500, 5'd12, 5'd13);
    step();
    offer2(32'h600, 5'd14, 5'd15);
    in_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq("r26_allowin", ws_allowin, 0);
      check_eq("r26_rf_we", rf_we, 2'b00);
      advance();
    end
    in_stall = 1'b0;
    settle();
    check_eq("r26_release", retire_mask, 2'b11);
    check_eq("r26_waddr0", rf_waddr[4:0], 5'd12);
    advance();
    idle(); step();

    // reset while stalled discards the held bundle
    offer2(32'h700, 5'd16, 5'd17);
    step();
    idle(); in_stall = 1'b1; in_reset = 1'b1;
    step();
    in_stall = 1'b0; in_reset = 1'b0;
    settle();
    check_eq("r18_retire", retire_mask, 2'b00);
    check_eq("r18_rf_we", rf_we, 2'b00);
    advance();

    // counter wrap: 7x2 + 1 + 2 = 17 -> 1 with 4-bit counters
    in_reset = 1'b1; step(); in_reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      offer2(32'h1000 + 32'(k * 16), 5'd1, 5'd2);
      if (k == 7) in_l[1].v = 1'b0;
      step();
    end
    idle(); step(); step();
    settle();
`ifdef WB_PERF_CNT_EN
    check_eq("r27_wrap", perf_retired, 1);
`else
    check_eq("r27_wrap", perf_retired, 0);
`endif
    advance();

    // random traffic
    for (int k = 0; k < 600; k++) begin
      in_reset = ($urandom_range(0, 63) == 0);
      in_stall = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < L; i++) in_l[i] = rnd_lane();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/wb_commit_stage.md
WB_COMMIT_STAGE -- requirements
Module: wb_commit_stage

Interface
REQ-001 The module SHALL have parameter LANES, default 2, giving the number of in-order instruction lanes; lane 0 is oldest; legal values are 1 to 4.
REQ-002 The module SHALL have parameter CNT_W, default 32, giving the width of each performance counter.
REQ-003 The module SHALL clock on clk, and reset SHALL be synchronous and active-high.
REQ-004 The module SHALL provide these ports (clock and reset first):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ws_stall  in  1  hold the bundle in WB (external CSR/TLB busy)
- ws_allowin  out  1  WB accepts a new bundle
- ms_to_ws_valid  in  1  bundle valid
- ms_lane_valid  in  LANES  per-lane valid
- ms_pc  in  LANES*32  per-lane PC
- ms_gr_we  in  LANES  GPR write request
- ms_dest  in  LANES*5  GPR destination
- ms_result  in  LANES*32  GPR write data
- ms_excp  in  LANES  lane raised an exception
- ms_ecode  in  LANES*6  ecode, valid when ms_excp=1
- ms_badv  in  LANES*32  bad VA
- ms_badv_vld  in  LANES  bad VA meaningful
- ms_ertn  in  LANES  ertn
- ms_refetch  in  LANES  CSR write, ll/sc or TLB op needing refetch
- ms_br_inst  in  LANES  branch
- ms_br_mispred  in  LANES  mispredicted branch
- rf_we  out  LANES  GPR write enable
- rf_waddr  out  LANES*5  GPR write address
- rf_wdata  out  LANES*32  GPR write data
- excp_flush  out  1  exception flush
- ertn_flush  out  1  ertn flush
- refetch_flush  out  1  refetch flush
- csr_era  out  32  PC of the flushing lane
- csr_ecode  out  6  ecode
- va_error  out  1  bad_va valid
- bad_va  out  32  bad VA
- retire_mask  out  LANES  lanes committing this cycle
- perf_retired  out  CNT_W  retired instruction count
- perf_br  out  CNT_W  retired branch count
- perf_mispred  out  CNT_W  retired mispredicted branch count

Function
REQ-005 The stage SHALL hold one registered bundle (ws_valid plus all per-lane fields), with ws_allowin = !ws_valid || !ws_stall.
REQ-006 When ms_to_ws_valid && ws_allowin and no flush output is asserted, the stage SHALL capture the bundle at the next clk; all commit outputs SHALL be combinational from the registered bundle, giving 1-cycle latency.
REQ-007 The flushing lane F SHALL be the lowest-index valid lane with ms_excp, ms_ertn or ms_refetch set; when no lane qualifies, F SHALL be LANES.
REQ-008 Lane i SHALL commit iff ws_valid && !ws_stall && lane_valid[i] && (i < F, or i == F && !excp[F]).
REQ-009 Lanes with i > F SHALL be killed: no rf_we, no counter effect.
REQ-010 rf_we[i] SHALL equal commit[i] && gr_we[i] && dest[i] != 0.
REQ-011 If a younger committing lane writes the same dest, the older lane's rf_we SHALL be cleared.
REQ-012 Flush outputs SHALL follow lane F, gated by ws_valid && !ws_stall:
- excp_flush = excp[F]
- ertn_flush = ertn[F] && !excp[F]
- refetch_flush = refetch[F] && !excp[F] && !ertn[F]
- csr_era = pc[F]
REQ-013 csr_ecode, bad_va and va_error SHALL come from lane F when excp_flush is set and SHALL be 0 otherwise; va_error = badv_vld[F].
REQ-014 On any flush, ws_valid SHALL clear at the next clk, and a bundle offered in the same cycle SHALL be dropped.
REQ-015 While ws_stall=1, the registered bundle SHALL be held, retire_mask SHALL be 0, and all flush outputs SHALL be 0.
REQ-016 retire_mask SHALL equal commit[LANES-1:0].

Reset
REQ-017 During reset, ws_valid SHALL clear, and all outputs except ws_allowin (1) and the data buses (don't-care, rf_we gated to 0) SHALL be 0.
REQ-018 Reset asserted mid-stall SHALL discard the held bundle with no flush or write.

Configuration
REQ-019 With WB_PERF_CNT_EN defined, each counter SHALL add, per clk, the popcount of committing lanes (retired), of committing lanes with br_inst (br), and of committing lanes with br_mispred (mispred).
REQ-020 Counters SHALL wrap modulo 2^CNT_W and SHALL reset to 0.
REQ-021 Without WB_PERF_CNT_EN, the counter registers SHALL not exist and perf_* SHALL be tied to 0.

Verification
REQ-022 The bench SHALL cover: LANES=2, both lanes valid, gr_we, dest 3/4 -> rf_we=11, retire_mask=11, perf_retired +2.
REQ-023 The bench SHALL cover: lane0 excp ecode 0x09, badv 0x1003, badv_vld=1, lane1 valid -> excp_flush=1, csr_era=pc0, bad_va=0x1003, rf_we=00, next-cycle bundle dropped.
REQ-024 The bench SHALL cover: lane1 refetch, both gr_we -> rf_we=11, refetch_flush=1, csr_era=pc1.
REQ-025 The bench SHALL cover: both lanes write dest 7 -> rf_we=10, rf_wdata lane1 only.
REQ-026 The bench SHALL cover: ws_stall=1 for 3 cycles with a held bundle -> ws_allowin=0, no writes; on release, a single commit.
REQ-027 The bench SHALL cover: with WB_PERF_CNT_EN and CNT_W=4, perf_retired=15 plus 2 retirements -> 1.
